// File: rtl/bram_bank_array.sv
// Multi-bank line memory: one write port into the newest bank, one broadcast read ordered oldest-to-newest.
// Optional reset-time clear sweep of every bank when BRAM_CLEAR_SWEEP_EN is defined.
module bram_bank_array #(
    parameter int unsigned RAM_WIDTH  = 13,
    parameter int unsigned NB_ADDRESS = 10,
    parameter int unsigned NB_BANKS   = 3,
    parameter int unsigned RD_MODE    = 0,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                            i_CLK,
    input  logic                            i_rst,
    input  logic                            i_wrEnable,
    input  logic [NB_ADDRESS-1:0]           i_writeAdd,
    input  logic [RAM_WIDTH-1:0]            i_data,
    input  logic                            i_rdEnable,
    input  logic [NB_ADDRESS-1:0]           i_readAdd,
    input  logic                            i_rotate,
    output logic [NB_BANKS*RAM_WIDTH-1:0]   o_data,
    output logic                            o_valid,
    output logic [$clog2(NB_BANKS)-1:0]     o_wrBank,
    output logic                            o_ready
);

    localparam int unsigned DEPTH = 2**NB_ADDRESS;
    localparam int unsigned BW    = $clog2(NB_BANKS);
    localparam int unsigned DW    = NB_BANKS*RAM_WIDTH;

    // Banks power up all ones; contents are never touched by reset.
    logic [RAM_WIDTH-1:0] r_mem [NB_BANKS][DEPTH] = '{default: '1};

    logic [BW-1:0]         r_wr_bank;
    logic [BW-1:0]         w_slot_bank [NB_BANKS];
    logic [DW-1:0]         w_rd_word;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic                  w_rot_fire;
    logic                  w_sweep_we;
    logic [NB_ADDRESS-1:0] w_sweep_add;
    logic                  r_s1_valid;
    logic [DW-1:0]         r_s1_data;

`ifdef BRAM_CLEAR_SWEEP_EN
    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [NB_ADDRESS-1:0] r_cnt;
    logic [NB_ADDRESS-1:0] w_cnt_nxt;
    logic                  r_ready;

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_state <= S_SWEEP;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // One address of every bank is cleared per cycle until the last one.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_sweep_we  = 1'b0;
        case (r_state)
            S_SWEEP: begin
                w_sweep_we = 1'b1;
                w_cnt_nxt  = r_cnt + NB_ADDRESS'(1);
                if (r_cnt == NB_ADDRESS'(DEPTH-1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_sweep_add = r_cnt;
    assign o_ready     = r_ready;
`else
    assign w_sweep_we  = 1'b0;
    assign w_sweep_add = '0;
    assign o_ready     = 1'b1;
`endif

    assign w_wr_fire  = i_wrEnable & o_ready;
    assign w_rd_fire  = i_rdEnable & o_ready;
    assign w_rot_fire = i_rotate   & o_ready;

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_wr_bank <= '0;
        end else if (w_rot_fire) begin
            r_wr_bank <= (r_wr_bank == BW'(NB_BANKS-1)) ? '0 : r_wr_bank + BW'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (w_sweep_we) begin
            for (int unsigned b = 0; b < NB_BANKS; b++) begin
                r_mem[b][w_sweep_add] <= '1;
            end
        end else if (w_wr_fire) begin
            r_mem[r_wr_bank][i_writeAdd] <= i_data;
        end
    end

    // Slot k reads bank (wr_bank+1+k) mod NB_BANKS so slot 0 is the oldest row.
    always_comb begin
        w_rd_word = '0;
        for (int unsigned k = 0; k < NB_BANKS; k++) begin
            w_slot_bank[k] = BW'((32'(r_wr_bank) + 32'd1 + 32'(k)) % NB_BANKS);
            w_rd_word[k*RAM_WIDTH +: RAM_WIDTH] = r_mem[w_slot_bank[k]][i_readAdd];
            if ((RD_MODE == 1) && w_wr_fire && (i_writeAdd == i_readAdd)
                && (w_slot_bank[k] == r_wr_bank)) begin
                w_rd_word[k*RAM_WIDTH +: RAM_WIDTH] = i_data;
            end
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) begin
                r_s1_data <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic          r_s2_valid;
            logic [DW-1:0] r_s2_data;

            always_ff @(posedge i_CLK) begin
                if (i_rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                    end
                end
            end

            assign o_valid = r_s2_valid;
            assign o_data  = r_s2_data;
        end else begin : g_noreg
            assign o_valid = r_s1_valid;
            assign o_data  = r_s1_data;
        end
    endgenerate

    assign o_wrBank = r_wr_bank;

endmodule

// File: tb/tb_bram_bank_array.sv
// Bench for bram_bank_array: two instances (read-first/no out reg, write-first/out reg) against a row-buffer model.
module tb_bram_bank_array;

    localparam int W     = 13;
    localparam int NA    = 4;
    localparam int NB    = 3;
    localparam int DEPTH = 16;
    localparam int DW    = NB*W;
`ifdef BRAM_CLEAR_SWEEP_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          i_rst, i_wrEnable, i_rdEnable, i_rotate;
    logic [NA-1:0] i_writeAdd, i_readAdd;
    logic [W-1:0]  i_data;
    logic [DW-1:0] oa_data, ob_data;
    logic          oa_valid, ob_valid, oa_ready, ob_ready;
    logic [1:0]    oa_bank, ob_bank;

    always #5 clk = ~clk;

    bram_bank_array #(.RAM_WIDTH(W), .NB_ADDRESS(NA), .NB_BANKS(NB), .RD_MODE(0), .OUT_REG(0)) u_a (
        .i_CLK(clk), .i_rst(i_rst), .i_wrEnable(i_wrEnable), .i_writeAdd(i_writeAdd),
        .i_data(i_data), .i_rdEnable(i_rdEnable), .i_readAdd(i_readAdd), .i_rotate(i_rotate),
        .o_data(oa_data), .o_valid(oa_valid), .o_wrBank(oa_bank), .o_ready(oa_ready));

    bram_bank_array #(.RAM_WIDTH(W), .NB_ADDRESS(NA), .NB_BANKS(NB), .RD_MODE(1), .OUT_REG(1)) u_b (
        .i_CLK(clk), .i_rst(i_rst), .i_wrEnable(i_wrEnable), .i_writeAdd(i_writeAdd),
        .i_data(i_data), .i_rdEnable(i_rdEnable), .i_readAdd(i_readAdd), .i_rotate(i_rotate),
        .o_data(ob_data), .o_valid(ob_valid), .o_wrBank(ob_bank), .o_ready(ob_ready));

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           qa[$];
    rd_t           qb[$];
    logic [W-1:0]  mem [NB][DEPTH];
    int            wr_bank;
    int            remaining;
    int            cyc;
    logic          ea_v, eb_v, e_ready;
    logic [DW-1:0] ea_d, eb_d;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Rows ordered oldest bank first; write-first substitutes the word being written this cycle.
    function automatic logic [DW-1:0] rows(input int ra, input bit wr, input int wa,
                                           input logic [W-1:0] d, input bit wfirst);
        logic [DW-1:0] r;
        logic [W-1:0]  w;
        int            b;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            b = (wr_bank + 1 + k) % NB;
            w = mem[b][ra];
            if (wfirst && wr && wa == ra && b == wr_bank) w = d;
            r[k*W +: W] = w;
        end
        return r;
    endfunction

    task automatic step(input bit rst, input bit wr, input int wa, input int d,
                        input bit rd, input int ra, input bit rot);
        rd_t t;
        i_rst      = rst;
        i_wrEnable = wr;
        i_writeAdd = NA'(wa);
        i_data     = W'(d);
        i_rdEnable = rd;
        i_readAdd  = NA'(ra);
        i_rotate   = rot;
        @(posedge clk);
        cyc++;
        if (rst) begin
            wr_bank = 0;
            qa.delete();
            qb.delete();
            ea_d = '0;
            eb_d = '0;
            if (SWEEP_EN) begin
                remaining = DEPTH;
                foreach (mem[i, j]) mem[i][j] = '1;
            end
        end else if (remaining > 0) begin
            remaining--;
        end else begin
            if (rd) begin
                t.due = cyc;     t.data = rows(ra, wr, wa, W'(d), 1'b0); qa.push_back(t);
                t.due = cyc + 1; t.data = rows(ra, wr, wa, W'(d), 1'b1); qb.push_back(t);
            end
            if (wr)  mem[wr_bank][wa] = W'(d);
            if (rot) wr_bank = (wr_bank + 1) % NB;
        end
        ea_v = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin t = qa.pop_front(); ea_v = 1'b1; ea_d = t.data; end
        eb_v = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin t = qb.pop_front(); eb_v = 1'b1; eb_d = t.data; end
        e_ready = (remaining == 0);
        #1;
        chk("a_valid", 64'(oa_valid), 64'(ea_v));
        chk("a_data",  64'(oa_data),  64'(ea_d));
        chk("a_wrbank", 64'(oa_bank), 64'(wr_bank));
        chk("a_ready", 64'(oa_ready), 64'(e_ready));
        chk("b_valid", 64'(ob_valid), 64'(eb_v));
        chk("b_data",  64'(ob_data),  64'(eb_d));
        chk("b_wrbank", 64'(ob_bank), 64'(wr_bank));
        chk("b_ready", 64'(ob_ready), 64'(e_ready));
    endtask

    task automatic drain_sweep();
        for (int i = 0; i < DEPTH + 4 && remaining > 0; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int nready;
        i_rst = 1'b1; i_wrEnable = 1'b0; i_rdEnable = 1'b0; i_rotate = 1'b0;
        i_writeAdd = '0; i_readAdd = '0; i_data = '0;
        foreach (mem[i, j]) mem[i][j] = '1;
        wr_bank = 0; remaining = 0; cyc = 0;
        ea_d = '0; eb_d = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        drain_sweep();

        // Fill three rows at address 5, then read the window.
        step(0, 1, 5, 'h0AA, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 5, 'h0BB, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 5, 'h0CC, 0, 0, 0);
        step(0, 0, 0, 0, 1, 5, 0);
        chk("basic_window", 64'(oa_data), 64'({13'h0CC, 13'h0BB, 13'h0AA}));
        step(0, 0, 0, 0, 0, 0, 0);
        chk("basic_pulse", 64'(oa_valid), 64'd0);

        step(0, 0, 0, 0, 0, 0, 1);
        chk("rot_wrap", 64'(oa_bank), 64'd0);
        step(0, 0, 0, 0, 1, 5, 0);
        chk("rot_window", 64'(oa_data), 64'({13'h0AA, 13'h0CC, 13'h0BB}));

        // Collision in the newest bank.
        step(0, 1, 7, 'h111, 0, 0, 0);
        step(0, 1, 7, 'h222, 1, 7, 0);
        chk("coll_rdfirst", 64'(oa_data[38:26]), 64'h111);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("coll_wrfirst", 64'(ob_data[38:26]), 64'h222);
        step(0, 0, 0, 0, 1, 7, 0);
        chk("coll_followup", 64'(oa_data[38:26]), 64'h222);

        // Write, rotate and read together at wr_bank=1.
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 1, 9, 'h055, 1, 9, 1);
        chk("wrr_bank", 64'(oa_bank), 64'd2);
        step(0, 0, 0, 0, 1, 9, 0);
        chk("wrr_landed", 64'(oa_data[25:13]), 64'h055);

        for (int a = 0; a < 4; a++) step(0, 0, 0, 0, 1, a, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Reset right behind a read discards it.
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_discard", 64'({oa_valid, ob_valid}), 64'd0);
        drain_sweep();

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) == 0, 1'($urandom), int'($urandom_range(0, DEPTH-1)),
                 int'($urandom_range(0, (1 << W) - 1)), 1'($urandom),
                 int'($urandom_range(0, DEPTH-1)), $urandom_range(0, 7) == 0);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        drain_sweep();

`ifdef BRAM_CLEAR_SWEEP_EN
        step(0, 1, 3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        nready = 0;
        for (int i = 0; i < DEPTH + 4 && remaining > 0; i++) begin
            step(0, 1, 3, 0, 0, 0, 1);
            if (!oa_ready) nready++;
        end
        chk("sweep_len", 64'(nready), 64'(DEPTH - 1));
        step(0, 0, 0, 0, 1, 3, 0);
        chk("sweep_clear", 64'(oa_data), 64'({3{13'h1FFF}}));
`else
        nready = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_bank_array.md
Name: bram_bank_array

Overview:
- Parametrised successor of the single-port-pair line memory: NB_BANKS independent simple-dual-port banks behind one write port and one broadcast read port.
- Write port fills the current "newest" bank. One read returns the same address from every bank, ordered oldest-to-newest, which gives the convolution window its row taps.
- A rotate strobe advances the newest-bank pointer, recycling the oldest bank for the next row.
- Adds read/write collision modes, an optional output register, and a read-valid pipeline.

Parameters:
- RAM_WIDTH, 13, data width per bank.
- NB_ADDRESS, 10, address width; each bank holds 2**NB_ADDRESS words.
- NB_BANKS, 3, number of banks/rows (legal range 2..8).
- RD_MODE, 0, same-bank same-address collision: 0 = read-first (old data), 1 = write-first (new data).
- OUT_REG, 0, 1 adds one output register stage (read latency 2 instead of 1).

Ports:
- i_CLK  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_wrEnable  in  1  write strobe.
- i_writeAdd  in  NB_ADDRESS  write address.
- i_data  in  RAM_WIDTH  write data.
- i_rdEnable  in  1  read strobe.
- i_readAdd  in  NB_ADDRESS  read address (all banks).
- i_rotate  in  1  advance write-bank pointer.
- o_data  out  NB_BANKS*RAM_WIDTH  slot k = bits [k*RAM_WIDTH +: RAM_WIDTH]; slot 0 oldest, slot NB_BANKS-1 newest.
- o_valid  out  1  o_data holds a completed read.
- o_wrBank  out  clog2(NB_BANKS)  current write-bank pointer.
- o_ready  out  1  block accepts reads/writes.

Behaviour:
- Reset: wr_bank=0, o_wrBank=0, o_valid=0, o_data=0, o_ready=1 (see optional feature). Memory contents are not cleared by reset.
- Power-up contents: all ones in every bank.
- Write: when i_wrEnable && o_ready, BRAM[wr_bank][i_writeAdd] <= i_data. Only one bank is written per cycle.
- Rotate: when i_rotate && o_ready, wr_bank <= (wr_bank==NB_BANKS-1) ? 0 : wr_bank+1. Takes effect the next cycle.
- Write and rotate in the same cycle: the write uses the pre-rotate pointer.
- Read: when i_rdEnable && o_ready, every bank reads i_readAdd.
  - Slot mapping is captured at issue: slot k <= bank (wr_bank+1+k) mod NB_BANKS.
  - A rotate in the same cycle does not affect that read's mapping.
- Latency: o_data/o_valid appear 1+OUT_REG cycles after the issue edge.
  - o_valid pulses once per accepted read and is back-to-back capable (one read per cycle).
- o_data holds its last value when no read is issued. o_valid=0 in that case.
- Collision (same cycle, read address == write address, bank == wr_bank):
  - RD_MODE=0: that slot returns the old word.
  - RD_MODE=1: that slot returns i_data.
  - Other slots are unaffected.
- Address wrap: none internal; addresses are used as given.
- Reset mid-read: in-flight reads are discarded; o_valid=0 the cycle after reset is sampled.

Optional Feature:
- Macro: BRAM_CLEAR_SWEEP_EN.
- Defined:
  - Reset starts a sweep FSM, IDLE -> SWEEP -> IDLE.
  - SWEEP: a counter 0..2**NB_ADDRESS-1 writes all ones into that address of every bank, one address per cycle.
  - o_ready=0 throughout SWEEP; reads, writes and rotates are ignored.
  - o_ready rises the cycle after the last address is written. Total 2**NB_ADDRESS cycles after reset release.
  - Reset during SWEEP restarts the counter at 0.
- Undefined: no FSM; o_ready is tied to 1; memory is not cleared by reset.

Test Plan:
- Basic read (RD_MODE=0, OUT_REG=0): reset; write 0x0AA to addr 5 in bank 0; rotate; write 0x0BB to addr 5 (bank 1); rotate; write 0x0CC (bank 2); read addr 5 -> 1 cycle later o_data = {0x0CC, 0x0BB, 0x0AA}? No: wr_bank=2, so slot0 = bank0 = 0x0AA, slot1 = 0x0BB, slot2 = 0x0CC; o_valid=1 for exactly 1 cycle.
- Rotation order: same contents, rotate once (wr_bank=0), read addr 5 -> slot0 = 0x0BB, slot1 = 0x0CC, slot2 = 0x0AA; o_wrBank wraps 2 -> 0.
- Collision: addr 7 bank wr_bank holds 0x111; same cycle write 0x222 and read addr 7. RD_MODE=0 -> newest slot = 0x111. RD_MODE=1 -> 0x222. A follow-up read returns 0x222.
- Latency/throughput: OUT_REG=1, reads of addrs 0,1,2,3 on consecutive cycles -> o_valid high for 4 consecutive cycles, starting 2 cycles after the first issue; data in order.
- Write+rotate+read same cycle: wr_bank=1, write 0x055 to addr 9, rotate, read addr 9 -> write lands in bank 1, read mapping uses wr_bank=1, next cycle o_wrBank=2.
- With BRAM_CLEAR_SWEEP_EN, NB_ADDRESS=4: write 0x000 to addr 3, pulse reset -> o_ready=0 for 16 cycles, writes ignored; then read addr 3 -> every slot = 0x1FFF.
